// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. Counts rising edges of the asynchronous
// sig_in over back-to-back windows of GATE_CYCLES clk_in cycles and publishes
// each window's count with a one-cycle freq_valid strobe.
// Optional feature macro: FREQ_METER_PERIOD_EN adds period_cycles/period_valid,
// the clk_in cycle count between consecutive rising edges while gating.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             overflow,
`ifdef FREQ_METER_PERIOD_EN
  output logic [31:0]      period_cycles,
  output logic             period_valid,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_e;

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q;
  logic [1:0]       arm_cnt_q;
  logic [31:0]      gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             ovf_q;
  logic [CNT_W-1:0] freq_count_q;
  logic             freq_valid_q;
  logic             overflow_q;
  logic             busy_q;

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;

  logic             edge_d;
  logic [CNT_W:0]   close_sum_d;
  logic             close_sat_d;
  logic             window_end_d;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Edge pulse and the closing-cycle sum; an edge landing in the closing
  // cycle is folded into the window that is being published.
  always_comb begin
    edge_d       = sync2_q & ~prev_q;
    close_sum_d  = {1'b0, edge_cnt_q} + (CNT_W+1)'(edge_d);
    close_sat_d  = (close_sum_d >= {1'b0, CNT_MAX});
    window_end_d = (gate_cnt_q == GATE_LAST);
  end

  // Control FSM with window/edge counters and registered result outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      arm_cnt_q    <= '0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      freq_count_q <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      freq_valid_q <= 1'b0;
      if (!en) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        arm_cnt_q  <= '0;
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= ARM;
            busy_q    <= 1'b1;
            arm_cnt_q <= '0;
          end
          ARM: begin
            if (arm_cnt_q == 2'd2) begin
              state_q    <= GATE;
              arm_cnt_q  <= '0;
              gate_cnt_q <= '0;
              edge_cnt_q <= '0;
              ovf_q      <= 1'b0;
            end else begin
              arm_cnt_q <= arm_cnt_q + 2'd1;
            end
          end
          GATE: begin
            if (window_end_d) begin
              // Publish and restart in the same edge so windows abut.
              freq_count_q <= close_sat_d ? CNT_MAX : close_sum_d[CNT_W-1:0];
              overflow_q   <= ovf_q | close_sat_d;
              freq_valid_q <= 1'b1;
              gate_cnt_q   <= '0;
              edge_cnt_q   <= '0;
              ovf_q        <= 1'b0;
            end else begin
              gate_cnt_q <= gate_cnt_q + 32'd1;
              if (edge_d && (edge_cnt_q != CNT_MAX)) begin
                edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                if (edge_cnt_q == (CNT_MAX - CNT_W'(1))) begin
                  ovf_q <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign freq_count = freq_count_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] per_cnt_q;
  logic        per_run_q;
  logic [31:0] period_q;
  logic        period_valid_q;

  // Edge-to-edge cycle counter; the first edge in GATE only arms it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q      <= '0;
      per_run_q      <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if ((state_q == GATE) && en) begin
        if (edge_d) begin
          per_cnt_q <= 32'd1;
          per_run_q <= 1'b1;
          if (per_run_q) begin
            period_q       <= per_cnt_q;
            period_valid_q <= 1'b1;
          end
        end else if (per_run_q && (per_cnt_q != '1)) begin
          per_cnt_q <= per_cnt_q + 32'd1;
        end
      end else begin
        per_cnt_q <= '0;
        per_run_q <= 1'b0;
      end
    end
  end

  assign period_cycles = period_q;
  assign period_valid  = period_valid_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (GATE_CYCLES=1000, CNT_W=8).
// The reference model works in time: each driven rising transition of sig_in
// is due at a known clock edge, and the window position follows from how many
// consecutive edges have sampled en high.
`timescale 1ns/1ps
module tb_freq_meter;
  localparam int unsigned G    = 1000;
  localparam int unsigned W    = 8;
  localparam int          MAXC = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] freq_count;
  logic         freq_valid;
  logic         overflow;
  logic         busy;
`ifdef FREQ_METER_PERIOD_EN
  logic [31:0]  period_cycles;
  logic         period_valid;
`endif

  freq_meter #(
    .GATE_CYCLES(G),
    .CNT_W      (W)
  ) dut (
    .clk_in       (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sig_in       (sig_in),
    .freq_count   (freq_count),
    .freq_valid   (freq_valid),
    .overflow     (overflow),
`ifdef FREQ_METER_PERIOD_EN
    .period_cycles(period_cycles),
    .period_valid (period_valid),
`endif
    .busy         (busy)
  );

  always #10 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          run = 0;
  int          acc = 0;
  int unsigned rises[$];
  logic        sig_drv = 1'b0;
  logic        en_drv = 1'b0;
  int          pub_cnt = 0;
  bit          pub_ovf = 1'b0;
  bit          have_last = 1'b0;
  int unsigned last_rise = 0;
  int unsigned pub_period = 0;
  bit          strobe_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run = 0;
    acc = 0;
    rises.delete();
    pub_cnt = 0;
    pub_ovf = 1'b0;
    have_last = 1'b0;
    pub_period = 0;
    sig_drv = 1'b0;
  endtask

  // Advance one clock: update the model for this edge, check, then drive.
  task automatic tick(input logic s, input logic e);
    bit exp_valid;
    bit exp_pvalid;
    bit hit;
    @(posedge clk);
    cyc++;
    exp_valid = 1'b0;
    exp_pvalid = 1'b0;
    hit = 1'b0;
    if (en_drv) run++; else run = 0;
    while (rises.size() > 0 && rises[0] <= cyc) begin
      if (rises[0] == cyc) hit = 1'b1;
      void'(rises.pop_front());
    end
    if (run >= 5) begin
      if (hit) begin
        acc++;
        if (have_last) begin
          exp_pvalid = 1'b1;
          pub_period = cyc - last_rise;
        end
        have_last = 1'b1;
        last_rise = cyc;
      end
      if (((run - 5) % G) == (G - 1)) begin
        exp_valid = 1'b1;
        pub_cnt = (acc >= MAXC) ? MAXC : acc;
        pub_ovf = (acc >= MAXC);
        acc = 0;
      end
    end else begin
      acc = 0;
      have_last = 1'b0;
    end
    #1;
    chk("freq_valid", freq_valid, exp_valid);
    chk("busy", busy, run > 0);
    chk("freq_count", freq_count, pub_cnt);
    chk("overflow", overflow, pub_ovf);
`ifdef FREQ_METER_PERIOD_EN
    chk("period_valid", period_valid, exp_pvalid);
    chk("period_cycles", period_cycles, pub_period);
`endif
    strobe_seen = freq_valid;
    if (s && !sig_drv) rises.push_back(cyc + 3);
    sig_in = s;
    en = e;
    sig_drv = s;
    en_drv = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    int hold;
    int off;
    int n;
    int pub_before;
    logic s;

    // Power-on reset.
    #5 rst_n = 1'b0;
    #2;
    chk("rst_freq_count", freq_count, 0);
    chk("rst_freq_valid", freq_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick(1'b0, 1'b0);

    // DC input: first strobe 1004 cycles after en rises, count 0.
    tick(1'b0, 1'b1);
    t0 = cyc;
    n = 0;
    while (!strobe_seen && n < 1100) begin tick(1'b0, 1'b1); n++; end
    chk("dc_first_strobe_latency", cyc - t0, 1004);
    chk("dc_count", freq_count, 0);
    repeat (1100) tick(1'b0, 1'b1);

    // Periodic input, toggle every 10 cycles (period 20).
    for (int i = 0; i < 3000; i++) tick(((i / 10) % 2) == 1, 1'b1);
    chk("periodic_count", freq_count, 50);
    chk("periodic_overflow", overflow, 0);

    // Toggle every cycle: 500 edges per window saturates the 8-bit count.
    for (int i = 0; i < 2100; i++) tick((i % 2) == 1, 1'b1);
    chk("sat_count", freq_count, MAXC);
    chk("sat_overflow", overflow, 1);

    // Idle input clears the count and the overflow flag.
    repeat (2100) tick(1'b0, 1'b1);
    chk("idle_count", freq_count, 0);
    chk("idle_overflow", overflow, 0);

    // Random input with occasional enable drops.
    s = 1'b0;
    hold = 0;
    off = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        s = ~s;
        hold = $urandom_range(1, 25);
      end
      hold--;
      if (off > 0) off--;
      else if ($urandom_range(0, 499) == 0) off = $urandom_range(1, 40);
      tick(s, off == 0);
    end

    // Abort: en sampled low at gate_cnt=500.
    n = 0;
    while (!(run >= 5 && ((run - 5) % G) == 498) && n < 3000) begin
      tick(((cyc / 10) % 2) == 1, 1'b1);
      n++;
    end
    chk("abort_reached", run >= 5 && ((run - 5) % G) == 498, 1);
    pub_before = pub_cnt;
    tick(1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_hold", freq_count, pub_before);
    tick(1'b0, 1'b1);
    t0 = cyc;
    n = 0;
    while (!strobe_seen && n < 1100) begin tick(1'b0, 1'b1); n++; end
    chk("abort_restart_latency", cyc - t0, 1004);

    // Reset mid-window at gate_cnt=700.
    n = 0;
    while (!(run >= 5 && ((run - 5) % G) == 699) && n < 3000) begin
      tick(((cyc / 7) % 2) == 1, 1'b1);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_freq_count", freq_count, 0);
    chk("midrst_freq_valid", freq_valid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_busy", busy, 0);
`ifdef FREQ_METER_PERIOD_EN
    chk("midrst_period_cycles", period_cycles, 0);
    chk("midrst_period_valid", period_valid, 0);
`endif
    model_reset();
    sig_in = 1'b0;
    en = 1'b1;
    en_drv = 1'b1;
    run = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    t0 = cyc;
    n = 0;
    while (!strobe_seen && n < 1100) begin tick(1'b0, 1'b1); n++; end
    chk("midrst_restart_latency", cyc - t0, 1004);

`ifdef FREQ_METER_PERIOD_EN
    // Period-37 input.
    for (int i = 0; i < 1200; i++) tick((i % 37) < 18, 1'b1);
    chk("period_37", period_cycles, 37);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter that runs on the 50 MHz system clock and measures an asynchronous external square wave. It counts rising edges of `sig_in` over a fixed window of `GATE_CYCLES` system clocks. The window defaults to 1 ms, the same time base as the 1 kHz tick, so the result reads directly in edges per millisecond. Windows run back to back while enabled, and each completed window publishes one count with a one-cycle valid strobe.

## Interface
- `GATE_CYCLES`, default 50000: window length in `clk_in` cycles; legal range 2..2^32-1.
- `CNT_W`, default 32: width of the edge counter and of `freq_count`.
- `clk_in`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `en`  in  1  measurement enable; synchronous to `clk_in`.
- `sig_in`  in  1  signal under measurement; asynchronous to `clk_in`.
- `freq_count`  out  CNT_W  rising edges counted in the last completed window.
- `freq_valid`  out  1  one-cycle strobe: `freq_count` and `overflow` were updated.
- `overflow`  out  1  the last completed window saturated `freq_count`.
- `busy`  out  1  high whenever the state is not IDLE.
- `period_cycles`  out  32  `clk_in` cycles between the last two rising edges; present only with `FREQ_METER_PERIOD_EN`.
- `period_valid`  out  1  one-cycle strobe on a `period_cycles` update; present only with `FREQ_METER_PERIOD_EN`.

## Operation
- Input path: `sig_in` passes through a 2-FF synchronizer, then a third register. A rising edge is `sync & ~prev`, which gives a one-cycle `edge` pulse.
- States:
  - IDLE: counters are held at 0.
  - ARM: 3 cycles that flush the synchronizer, counted by `arm_cnt` 0..2.
  - GATE: counting.
- Transitions:
  - IDLE → ARM when `en`=1.
  - ARM → GATE when `arm_cnt`=2 and `en`=1.
  - Any state → IDLE when `en`=0.
- GATE:
  - `gate_cnt` increments every cycle. `edge_cnt` increments on `edge` and saturates at 2^CNT_W-1; reaching saturation sets the internal `ovf` flag.
  - When `gate_cnt`=GATE_CYCLES-1, the window closes. On that edge:
    - `freq_count` ← `edge_cnt + edge`, saturated to 2^CNT_W-1.
    - `overflow` ← `ovf`, or 1 if the addition saturated.
    - `freq_valid` ← 1 for one cycle.
    - `gate_cnt`, `edge_cnt` and `ovf` clear.
    - The state stays GATE, so no cycle is lost between windows.
- `en` falling mid-window aborts the window: no `freq_valid`, internal counters clear. `freq_count` and `overflow` hold their last published values.
- Simultaneous events: an edge in the closing cycle counts in the closing window. An edge in the first cycle of the next window counts there. Every edge is counted exactly once.
- Reset (asynchronous, any time, including mid-window): state IDLE, synchronizer 0, all counters 0, every output 0. No strobe is issued on or after reset until a full window completes.

## Timing
- `sig_in` rising to `edge` pulse: 3 `clk_in` cycles, with ±1 cycle sampling uncertainty.
- From `en` rising, the first window starts 4 cycles later (1 cycle IDLE→ARM, then 3 cycles of ARM).
- The first `freq_valid` follows after another GATE_CYCLES cycles. Subsequent strobes are exactly GATE_CYCLES apart.
- `freq_count` and `overflow` change only in the same cycle that `freq_valid` is 1; they are stable otherwise.
- `busy` is registered and follows the state.
- Maximum measurable input frequency is `clk_in`/2 (25 MHz). Above that, edges alias.

## Configuration
- `FREQ_METER_PERIOD_EN` defined:
  - Adds `period_cycles` and `period_valid`.
  - A 32-bit counter runs in GATE and restarts at 1 on each `edge`.
  - The first edge after entering GATE only starts the counter. Each later edge latches the counter value into `period_cycles` and pulses `period_valid`.
  - The counter saturates at 2^32-1.
  - Leaving GATE discards the partial measurement; `period_cycles` holds its last value.
  - Reset value of both ports is 0.
- `FREQ_METER_PERIOD_EN` not defined: both ports and all period logic are absent. Frequency behavior is identical in both builds.

## Test plan
- Periodic input: GATE_CYCLES=1000, `sig_in` toggles every 10 cycles (period 20), `en`=1 → every `freq_valid` after the first window shows `freq_count`=50 and `overflow`=0, and strobes are 1000 cycles apart.
- DC input: `sig_in` held at 0, `en`=1 → `freq_count`=0 on every strobe, first strobe at cycle 1004 after `en` rises.
- Overflow: CNT_W=4, period-20 input for 1000 cycles → `freq_count`=15 and `overflow`=1. The next window with `sig_in` idle → `freq_count`=0 and `overflow`=0.
- Abort: drop `en` at `gate_cnt`=500 → no `freq_valid`, `busy`=0 one cycle later, `freq_count` holds the prior value. Re-assert `en` → first strobe 1004 cycles later.
- Reset mid-window: pull `rst_n` low at `gate_cnt`=700 → all outputs 0 immediately. On release with `en`=1, the first strobe arrives 1004 cycles later.
- Period build (`FREQ_METER_PERIOD_EN`): input period 37 cycles → `period_cycles`=37 with one `period_valid` per edge, starting from the second edge after entering GATE.
